// File: rtl/add_sub_seq.sv
`default_nettype none
// add_sub_seq: WIDTH-bit add/sub computed CHUNK bits per clock, NZCV flags (rev 1.0).
// Optional saturation on signed overflow: define ADD_SUB_SEQ_SAT_EN (adds sat_i).
module add_sub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
`ifdef ADD_SUB_SEQ_SAT_EN
  input  logic             sat_i,
`endif
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             add_sub_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o,
  output logic             N_o,
  output logic             Z_o,
  output logic             V_o
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [0:0]    IDLE     = 1'b0;
  localparam logic [0:0]    BUSY     = 1'b1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] shadow;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sat_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] psum;
  logic             cout;
  logic [WIDTH-1:0] full;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             last;

  assign base = 32'(cnt) * 32'(CHUNK);
  assign a_ch = CHUNK'(a_q >> base);
  assign b_ch = CHUNK'(b_q >> base);
  assign {cout, psum} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};

  // Shadow is cleared at start, so each chunk lands in zeroed bits.
  assign full = shadow | (WIDTH'(psum) << base);
  assign last = (cnt == LAST_CNT);

  // b_q already holds ~B for subtract, so one rule covers both operations.
  assign ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (full[WIDTH-1] != a_q[WIDTH-1]);

  assign result = (sat_q && ovf) ? {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}} : full;

  assign busy_o = (state == BUSY);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      shadow <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sat_q  <= 1'b0;
      done_o <= 1'b0;
      S_o    <= '0;
      C_o    <= 1'b0;
      N_o    <= 1'b0;
      Z_o    <= 1'b0;
      V_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            a_q    <= A_i;
            b_q    <= add_sub_i ? ~B_i : B_i;
            carry  <= add_sub_i;
            shadow <= '0;
            cnt    <= '0;
`ifdef ADD_SUB_SEQ_SAT_EN
            sat_q  <= sat_i;
`else
            sat_q  <= 1'b0;
`endif
            state  <= BUSY;
          end
        end
        BUSY: begin
          shadow <= full;
          carry  <= cout;
          cnt    <= cnt + 1'b1;
          if (last) begin
            S_o    <= result;
            C_o    <= cout;
            N_o    <= result[WIDTH-1];
            Z_o    <= (result == '0);
            V_o    <= ovf;
            done_o <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_sub_seq.sv
`default_nettype none
// tb_add_sub_seq: directed vectors plus a cycle-level reference model for add_sub_seq.
module tb_add_sub_seq;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int NCH   = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sat = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             op = 1'b0;
  logic             busy, done, c, n, z, v;
  logic [WIDTH-1:0] s;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  add_sub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start),
`ifdef ADD_SUB_SEQ_SAT_EN
    .sat_i    (sat),
`endif
    .A_i      (a),
    .B_i      (b),
    .add_sub_i(op),
    .busy_o   (busy),
    .done_o   (done),
    .S_o      (s),
    .C_o      (c),
    .N_o      (n),
    .Z_o      (z),
    .V_o      (v)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the operands seen at the accepted start.
  logic             m_busy = 1'b0, m_done = 1'b0;
  logic [WIDTH-1:0] m_s = '0, p_s = '0;
  logic             m_c = 1'b0, m_n = 1'b0, m_z = 1'b0, m_v = 1'b0;
  logic             p_c = 1'b0, p_v = 1'b0;
  int               rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_s = '0;
      m_c = 1'b0; m_n = 1'b0; m_z = 1'b0; m_v = 1'b0; rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        rem--;
        if (rem == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_s = p_s; m_c = p_c; m_v = p_v;
          m_n = p_s[WIDTH-1]; m_z = (p_s == 0);
        end
      end else if (start) begin
        int sa, sb, sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sr = op ? sa - sb : sa + sb;
        p_v = (sr > 32767) || (sr < -32768);
        p_c = op ? (int'(a) >= int'(b)) : ((int'(a) + int'(b)) > 65535);
        p_s = WIDTH'(sr);
        if (sat && p_v) p_s = (sr > 0) ? 16'h7FFF : 16'h8000;
        m_busy = 1'b1;
        rem = NCH;
      end
    end
  end

  always @(negedge clk) begin
    check("busy_vs_model", 32'(busy), 32'(m_busy));
    check("done_vs_model", 32'(done), 32'(m_done));
    check("flags_vs_model", {28'(0), c, n, z, v}, {28'(0), m_c, m_n, m_z, m_v});
    check("S_vs_model", 32'(s), 32'(m_s));
  end

  always @(posedge clk) if (done === 1'b1) done_seen++;

  // One operation with hand-computed result; optionally disturbs inputs mid-flight.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic iop,
                        input logic isat, input logic disturb,
                        input logic [15:0] es, input logic [3:0] ecnzv);
    int lat, busy_hi;
    @(negedge clk);
    a = ia; b = ib; op = iop; sat = isat; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_hi = busy ? 1 : 0;
    while (lat < 20) begin
      @(posedge clk); lat++; #1;
      if (disturb && lat == 1) begin
        a = ~ia; b = ib ^ 16'h5A5A; op = ~iop; start = 1'b1;
      end
      if (disturb && lat == 2) start = 1'b0;
      if (done) break;
      if (busy) busy_hi++;
    end
    check("latency", 32'(lat), 32'(NCH));
    check("busy_cycles", 32'(busy_hi), 32'(NCH));
    check("S_literal", 32'(s), 32'(es));
    check("CNZV_literal", {28'(0), c, n, z, v}, {28'(0), ecnzv});
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'(0));
    a = 16'hDEAD; b = 16'hBEEF;
    repeat (3) @(posedge clk);
  endtask

  initial begin : main
    int lat, d0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_outs", {11'(0), done, s, c, n, z, v}, 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    //     A        B        op    sat   dist  S        CNZV
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0003, 4'b0000);
    run_op(16'h0003, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0001, 4'b1000);
    run_op(16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0, 16'h0000, 4'b1010);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 4'b0101);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h7FFF, 4'b1001);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1010);
    run_op(16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0, 16'hBBBC, 4'b0100);
    run_op(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 1'b1, 16'h0FFF, 4'b0000);
`ifdef ADD_SUB_SEQ_SAT_EN
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 4'b0001);
`endif

    // start held high through the done cycle: back-to-back every NCH+1 edges
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; op = 1'b0; sat = 1'b0; start = 1'b1;
    lat = 0;
    while (lat < 30 && done !== 1'b1) begin @(posedge clk); #1; end
    d0 = 0;
    while (lat < 30) begin
      @(posedge clk); #1; lat++;
      if (done) break;
    end
    check("b2b_spacing", 32'(lat), 32'(NCH + 1));
    check("b2b_S", 32'(s), 32'h0030);
    @(negedge clk);
    start = 1'b0;
    repeat (NCH + 3) @(posedge clk);

    // asynchronous reset during the second busy cycle
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #3;
    d0 = done_seen;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_outs", {11'(0), done, s, c, n, z, v}, 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NCH + 4) @(posedge clk);
    #1;
    check("no_done_after_rst", 32'(done_seen), 32'(d0));
    run_op(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0, 16'h8000, 4'b0101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/add_sub_seq.md
# add_sub_seq

Parametrised multi-cycle adder/subtractor with NZCV flags, the successor of the 4-bit combinational add/sub block. Operands of WIDTH bits are captured on a start pulse. The sum is computed CHUNK bits per clock through a single CHUNK-bit adder slice, with the carry held in a register between chunks. Result and flags are registered and held until the next operation completes. It is used as the shared arithmetic unit wherever WIDTH-bit add/sub is needed at low area.

## Interface
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per clock. NCH = WIDTH/CHUNK (number of chunks).
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  reset; asynchronous, active-low.
- start_i  input  1  request; sampled only while idle.
- A_i  input  WIDTH  operand A (two's complement or unsigned).
- B_i  input  WIDTH  operand B.
- add_sub_i  input  1  0 = A+B, 1 = A−B.
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle pulse: S_o and flags just updated.
- S_o  output  WIDTH  result.
- C_o  output  1  carry-out of MSB (for subtract: 1 = no borrow).
- N_o  output  1  S_o[WIDTH-1].
- Z_o  output  1  S_o == 0.
- V_o  output  1  signed overflow.

## Operation
- FSM has two states, IDLE and BUSY. The chunk counter is ceil(log2(NCH)) bits wide, minimum 1 bit.
- IDLE with start_i=1 at an edge:
  - latch A_i; latch B_i, inverted if add_sub_i=1;
  - latch add_sub_i;
  - set carry register = add_sub_i;
  - clear counter;
  - enter BUSY.
- IDLE with start_i=0: remain in IDLE.
- BUSY, each edge:
  - chunk k = counter (LSB chunk first) computes A[k] + B'[k] + carry;
  - store the CHUNK-bit partial sum into the shadow result;
  - update the carry register;
  - increment the counter.
- On the edge processing chunk NCH−1:
  - S_o, C_o, N_o, Z_o, V_o load from the completed shadow result and final carry;
  - done_o is set;
  - state returns to IDLE.
- V rules:
  - add: V = (A[MSB] == B[MSB]) && (S[MSB] != A[MSB]);
  - sub: V = (A[MSB] != B[MSB]) && (S[MSB] != A[MSB]).
- Results wrap modulo 2^WIDTH.
- start_i during BUSY is ignored. It is not queued.
- A_i, B_i, add_sub_i changes during BUSY have no effect on the result.
- S_o and flags are stable outside the done edge; they hold the previous result throughout BUSY.
- Reset asserted at any time, including mid-operation:
  - immediately forces IDLE;
  - the pending result is discarded and no done_o is issued;
  - all outputs return to reset values.

## Timing
- Reset values: busy_o=0, done_o=0, S_o=0, C_o=0, N_o=0, Z_o=0, V_o=0. Z_o is registered and resets to 0 despite S_o=0.
- start_i sampled high at edge E0: busy_o=1 from E0 through E(NCH).
- At E(NCH): busy_o=0, done_o=1, and the result is visible.
- At E(NCH+1): done_o=0.
- Start-to-result latency: NCH clock edges.
- A start_i sampled at E(NCH+1), the cycle done_o is high, is accepted. Maximum throughput is one operation per NCH+1 cycles.
- NCH=1 (CHUNK=WIDTH): the result appears one edge after start.
- done_o never asserts without a preceding accepted start.

## Configuration
- Macro: ADD_SUB_SEQ_SAT_EN.
- Defined:
  - an extra input sat_i (1 bit) is latched with the operands at start;
  - if sat_i=1 and V=1, S_o clamps to 2^(WIDTH−1)−1 when A[MSB]=0, or −2^(WIDTH−1) when A[MSB]=1;
  - N_o and Z_o are computed from the clamped value;
  - V_o and C_o still report the unclamped operation.
- Undefined: no sat_i port; results always wrap.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 (NCH=4).
- Add, no flags: 0x0001 + 0x0002 → done_o exactly 4 edges after start, S_o=0x0003, C=0 N=0 Z=0 V=0, busy_o high 4 cycles, done_o high 1 cycle.
- Subtract: 0x0003 − 0x0002 → S_o=0x0001, C=1 N=0 Z=0 V=0.
- Subtract to zero: 0x0005 − 0x0005 → S_o=0x0000, C=1 Z=1 N=0 V=0.
- Overflow:
  - 0x7FFF + 0x0001 → S_o=0x8000, N=1 V=1 C=0;
  - 0x8000 − 0x0001 → S_o=0x7FFF, C=1 V=1 N=0;
  - with ADD_SUB_SEQ_SAT_EN and sat_i=1, the first case gives S_o=0x7FFF, N=0 V=1.
- Handshake:
  - start_i pulsed again during BUSY → ignored, exactly one done_o;
  - A_i changed mid-operation → result unchanged;
  - start_i held high through the done_o cycle → second operation accepted, next done_o 5 cycles after the first.
- Reset mid-operation: rst_n_i low during the 2nd BUSY cycle → busy_o and all outputs go to 0 without waiting for a clock edge; no done_o after release; the next start completes normally.
